debug_probe_monitor: RTL and testbench
======================================

Name: debug_probe_monitor

Overview:
- Receive-side companion to the STATE_LED1 debug observation mux.
- Samples the currently selected single-bit probe over a programmable gate window and counts rising edges and high cycles.
- Reports results, tagged with the probe select active at the time, to the register bank through a valid/ready handshake.
- This lets firmware characterise FSM indices, ROIC timing strobes and AED signals without a scope.

Parameters:
SYNC_STAGES, 2, synchroniser depth on probe_in (min 2)
CNT_W, 16, edge counter width (saturating)
WIN_W, 32, window length and high-cycle counter width (saturating)

Ports:
clk_20mhz  input  1  system clock, 20 MHz
rst_20mhz  input  1  synchronous reset, active-high
probe_in  input  1  selected debug bit (mux output, treated as asynchronous)
probe_sel  input  8  current state_led_ctr select value
start  input  1  single-cycle pulse, begins a measurement
window_cycles  input  WIN_W  gate length in clk_20mhz cycles
busy  output  1  high in ARM and MEASURE
result_valid  output  1  result available, held until accepted
result_ready  input  1  register bank accepts result
edge_count  output  CNT_W  rising edges seen in window
high_count  output  WIN_W  cycles the synchronised probe was high in window
result_sel  output  8  probe_sel captured at ARM
aborted  output  1  window terminated early by select change
level_now  output  1  synchronised probe level, free-running

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, synchroniser flops 0.
- Synchroniser: probe_in passes through SYNC_STAGES flops to give probe_s; level_now = probe_s.
- A rising edge is probe_s=1 with previous probe_s=0, registered one cycle later.
- FSM has four states: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - start=1 -> ARM.
  - start=0 -> stay in IDLE.
- ARM (exactly 1 cycle):
  - Clear edge_count, high_count and aborted.
  - result_sel <= probe_sel.
  - Window counter <= window_cycles.
  - Seed edge-detector history with current probe_s, so a probe already high gives no edge.
  - If window_cycles==0 -> DONE with zero counts; otherwise -> MEASURE.
- MEASURE, each cycle:
  - high_count += probe_s.
  - edge_count += edge.
  - Window counter decrements.
  - Both counters saturate at all-ones and never wrap.
  - When the window counter reaches 0 after exactly window_cycles samples -> DONE.
- Select change: if probe_sel != result_sel during MEASURE, that cycle's sample is not counted. aborted<=1 and the FSM goes to DONE. Counts hold the partial values.
- DONE:
  - result_valid=1; edge_count, high_count, result_sel and aborted stay stable.
  - result_valid && result_ready -> IDLE, and result_valid drops the next cycle.
  - Result registers keep their values until the next ARM.
- start while busy or in DONE is ignored (not queued).
- Same-cycle start and acceptance in DONE: the handshake completes and start is dropped.
- busy = (state==ARM || state==MEASURE).
- Latency:
  - The first counted sample is the cycle after ARM.
  - probe_in to its effect on the counters is SYNC_STAGES+1 cycles.
  - result_valid asserts the cycle after the last window sample.
- Reset mid-measurement: back to IDLE, all outputs cleared, no result produced.

Test Plan:
- Period test: probe_in = square wave, period 10 cycles, 50% duty; probe_sel=8'h30; start with window_cycles=1000 -> edge_count=100 (±1), high_count=500 (±5), result_sel=8'h30, aborted=0.
- Stuck-high probe: probe_in=1 throughout; window_cycles=64 -> edge_count=0, high_count=64.
- Zero window: window_cycles=0 -> result_valid asserts 2 cycles after start, all counts 0, aborted=0.
- Select change: window_cycles=1000; probe_sel changes 8'h02->8'h03 at cycle 300 of MEASURE -> aborted=1, high_count<=300, result_sel=8'h02.
- Saturation and handshake:
  - CNT_W=4 and 1-cycle toggle over 100 cycles -> edge_count=15.
  - Hold result_ready=0 for 20 cycles -> result_valid and results stable, and a start pulse during the hold is ignored.
  - After ready: return to IDLE, busy=0.
- Reset mid-op: assert rst_20mhz during MEASURE -> next cycle busy=0, result_valid=0, counts 0; a subsequent start measures normally.

Source files
------------

// File: rtl/debug_probe_monitor.sv
// debug_probe_monitor
//   Receive-side companion to the debug observation mux. This block synchronises
//   the currently selected probe bit. Over a programmable gate window it counts
//   rising edges and high cycles. It then hands the tagged result to the register
//   bank through a valid/ready handshake.
//
// Ports:
//   clk_20mhz, rst_20mhz    clock, synchronous active-high reset
//   probe_in                selected debug bit (asynchronous)
//   probe_sel[7:0]          current mux select, captured as the result tag
//   start                   single-cycle pulse that begins a measurement
//   window_cycles[WIN_W]    gate length in clock cycles (0 = empty window)
//   busy                    measurement armed or in progress
//   result_valid/ready      result handshake; results held until accepted
//   edge_count[CNT_W]       rising edges in window (saturating)
//   high_count[WIN_W]       high cycles in window (saturating)
//   result_sel[7:0]         probe_sel captured when the window was armed
//   aborted                 window cut short by a select change
//   level_now               synchronised probe level, free-running
module debug_probe_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 32
) (
    input  logic             clk_20mhz,
    input  logic             rst_20mhz,
    input  logic             probe_in,
    input  logic [7:0]       probe_sel,
    input  logic             start,
    input  logic [WIN_W-1:0] window_cycles,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] edge_count,
    output logic [WIN_W-1:0] high_count,
    output logic [7:0]       result_sel,
    output logic             aborted,
    output logic             level_now
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   probe_s;
    logic                   prev_s;
    logic                   rise;
    logic [WIN_W-1:0]       win_cnt;

    assign probe_s   = sync_q[SYNC_STAGES-1];
    assign level_now = probe_s;

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) sync_q <= '0;
        else           sync_q <= {sync_q[SYNC_STAGES-2:0], probe_in};
    end

    // The history flop tracks probe_s every cycle. It therefore holds the
    // ARM-cycle level at the first MEASURE sample, which is the required seed.
    // As a result, a probe that is already high does not count as an edge.
    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) prev_s <= 1'b0;
        else           prev_s <= probe_s;
    end

    assign rise         = probe_s & ~prev_s;
    assign busy         = (state == S_ARM) || (state == S_MEASURE);
    assign result_valid = (state == S_DONE);

    always_ff @(posedge clk_20mhz) begin
        if (rst_20mhz) begin
            state      <= S_IDLE;
            win_cnt    <= '0;
            edge_count <= '0;
            high_count <= '0;
            result_sel <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_ARM;
                end
                S_ARM: begin
                    edge_count <= '0;
                    high_count <= '0;
                    aborted    <= 1'b0;
                    result_sel <= probe_sel;
                    win_cnt    <= window_cycles;
                    state      <= (window_cycles == '0) ? S_DONE : S_MEASURE;
                end
                S_MEASURE: begin
                    if (probe_sel != result_sel) begin
                        // The mux now shows a different signal, so this
                        // sample is discarded and the partial counts are kept.
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        if (probe_s && (high_count != '1)) high_count <= high_count + 1'b1;
                        if (rise && (edge_count != '1))    edge_count <= edge_count + 1'b1;
                        win_cnt <= win_cnt - 1'b1;
                        if (win_cnt == WIN_W'(1)) state <= S_DONE;
                    end
                end
                default: begin
                    // In DONE, a start pulse is ignored. This also applies
                    // when start arrives in the same cycle as acceptance.
                    if (result_ready) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_probe_monitor.sv
module tb_debug_probe_monitor;

    logic        clk_20mhz = 1'b0;
    logic        rst_20mhz;
    logic        probe_in;
    logic [7:0]  probe_sel;
    logic        start;
    logic [31:0] window_cycles;
    logic        result_ready;

    logic        busy, result_valid, aborted, level_now;
    logic [15:0] edge_count;
    logic [31:0] high_count;
    logic [7:0]  result_sel;

    logic        s_busy, s_valid, s_aborted, s_level;
    logic [3:0]  s_edge;
    logic [31:0] s_high;
    logic [7:0]  s_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0 hold probe_in, 1 square period 10, 2 toggle each cycle
    int phase   = 0;

    always #25 clk_20mhz = ~clk_20mhz;

    debug_probe_monitor dut (
        .clk_20mhz(clk_20mhz), .rst_20mhz(rst_20mhz), .probe_in(probe_in),
        .probe_sel(probe_sel), .start(start), .window_cycles(window_cycles),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .edge_count(edge_count), .high_count(high_count), .result_sel(result_sel),
        .aborted(aborted), .level_now(level_now)
    );

    debug_probe_monitor #(.CNT_W(4)) dut_sat (
        .clk_20mhz(clk_20mhz), .rst_20mhz(rst_20mhz), .probe_in(probe_in),
        .probe_sel(probe_sel), .start(start), .window_cycles(window_cycles),
        .busy(s_busy), .result_valid(s_valid), .result_ready(result_ready),
        .edge_count(s_edge), .high_count(s_high), .result_sel(s_sel),
        .aborted(s_aborted), .level_now(s_level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_20mhz);
        #1;
        if (mode == 1) begin
            phase    = (phase + 1) % 10;
            probe_in = (phase < 5);
        end else if (mode == 2) begin
            probe_in = ~probe_in;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input logic [31:0] win);
        window_cycles = win;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!result_valid && k < budget) begin
            step();
            k++;
        end
        if (!result_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    initial begin
        rst_20mhz = 1'b1; probe_in = 1'b0; probe_sel = 8'h00; start = 1'b0;
        window_cycles = '0; result_ready = 1'b0;
        steps(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_edge", edge_count, 0);
        chk("rst_high", high_count, 0);
        chk("rst_sel", result_sel, 0);
        chk("rst_abort", aborted, 0);
        chk("rst_level", level_now, 0);
        rst_20mhz = 1'b0;

        // Synchroniser latency: two flops
        probe_in = 1'b1;
        step();
        chk("sync_lat1", level_now, 0);
        step();
        chk("sync_lat2", level_now, 1);

        // Stuck-high probe, window 64
        probe_sel = 8'h11;
        steps(3);
        do_start(64);
        chk("stuck_busy_arm", busy, 1);
        wait_done("stuck", 200);
        chk("stuck_edge", edge_count, 0);
        chk("stuck_high", high_count, 64);
        chk("stuck_sel", result_sel, 8'h11);
        chk("stuck_busy_done", busy, 0);
        accept();
        chk("stuck_idle_valid", result_valid, 0);

        // Zero window: valid two cycles after the start pulse
        do_start(0);
        chk("zero_valid_1", result_valid, 0);
        step();
        chk("zero_valid_2", result_valid, 1);
        chk("zero_edge", edge_count, 0);
        chk("zero_high", high_count, 0);
        chk("zero_abort", aborted, 0);
        accept();

        // Period test: square wave period 10, window 1000
        mode = 1; phase = 0; probe_in = 1'b1; probe_sel = 8'h30;
        steps(20);
        do_start(1000);
        steps(1000);
        chk("period_valid_early", result_valid, 0);
        step();
        chk("period_valid", result_valid, 1);
        chk("period_edge", edge_count, 100);
        chk("period_high", high_count, 500);
        chk("period_sel", result_sel, 8'h30);
        chk("period_abort", aborted, 0);
        chk("period_sat_edge", s_edge, 15);

        // Hold ready low for 20 cycles; a start pulse in DONE is ignored
        steps(5);
        start = 1'b1; step(); start = 1'b0;
        steps(14);
        chk("hold_valid", result_valid, 1);
        chk("hold_busy", busy, 0);
        chk("hold_edge", edge_count, 100);
        chk("hold_high", high_count, 500);
        chk("hold_sel", result_sel, 8'h30);
        accept();
        chk("acc_valid", result_valid, 0);
        chk("acc_busy", busy, 0);
        step();
        chk("acc_no_queue", busy, 0);
        chk("acc_keep_edge", edge_count, 100);

        // Toggle each cycle over 100 samples; the 4-bit instance saturates
        mode = 2;
        steps(4);
        do_start(100);
        wait_done("toggle", 200);
        chk("toggle_edge", edge_count, 50);
        chk("toggle_high", high_count, 50);
        chk("toggle_sat_edge", s_edge, 15);
        chk("toggle_sat_high", s_high, 50);

        // Start coincident with acceptance is dropped
        start = 1'b1; result_ready = 1'b1;
        step();
        start = 1'b0; result_ready = 1'b0;
        chk("same_cyc_valid", result_valid, 0);
        step();
        chk("same_cyc_busy", busy, 0);

        // Select change after 300 MEASURE samples
        mode = 1; probe_sel = 8'h02;
        steps(10);
        do_start(1000);
        step();
        steps(300);
        chk("sel_still_busy", busy, 1);
        probe_sel = 8'h03;
        step();
        chk("sel_valid", result_valid, 1);
        chk("sel_abort", aborted, 1);
        chk("sel_high", high_count, 150);
        chk("sel_edge", edge_count, 30);
        chk("sel_tag", result_sel, 8'h02);
        accept();

        // Reset mid-measurement, then a normal measurement
        do_start(1000);
        steps(50);
        rst_20mhz = 1'b1;
        step();
        rst_20mhz = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", result_valid, 0);
        chk("mrst_edge", edge_count, 0);
        chk("mrst_high", high_count, 0);
        steps(5);
        chk("mrst_no_result", result_valid, 0);
        mode = 0; probe_in = 1'b1; probe_sel = 8'h44;
        steps(4);
        do_start(64);
        wait_done("post_rst", 200);
        chk("post_rst_high", high_count, 64);
        chk("post_rst_edge", edge_count, 0);
        chk("post_rst_sel", result_sel, 8'h44);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
